// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding word requests to
// instruction memory, buffers responses in a 2-entry queue and drives the DE latch.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_IR   = 32'h00000013
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MEM_STALL,
    input  logic        DE_BR_STALL,
    input  logic        BR_RESOLVE,
    input  logic        BR_TAKEN,
    input  logic [63:0] BR_TARGET,
    input  logic        TRAP,
    input  logic [63:0] DE_MTVEC,
    output logic        IMEM_REQ,
    output logic [63:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [63:0] DE_NPC,
    output logic [31:0] DE_IR,
    output logic        DE_V,
    output logic        DBG_STATE
);

    // Request channel: a request transfers on a rising edge where IMEM_REQ && IMEM_READY;
    // IMEM_ADDR is held while IMEM_REQ waits, except on a redirect cycle.
    typedef enum logic {ST_RUN = 1'b0, ST_BR_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic        out_q, out_d;
    logic        drop_q, drop_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        hd_q, hd_d;
    logic [63:0] q_npc_q [2];
    logic [31:0] q_ir_q  [2];
    logic [63:0] de_npc_q, de_npc_d;
    logic [31:0] de_ir_q, de_ir_d;
    logic        de_v_q, de_v_d;

    logic        rsp, br_redir, redirect, credit_ok, req, accept, push, pop, wr_idx;
    logic [63:0] redir_pc, fetch_pc;

    always_comb begin
        rsp       = IMEM_RVALID && out_q;
        br_redir  = (state_q == ST_BR_WAIT) && BR_RESOLVE && BR_TAKEN;
        redirect  = TRAP || br_redir;
        redir_pc  = TRAP ? DE_MTVEC : BR_TARGET;
        fetch_pc  = redirect ? redir_pc : pc_q;
        credit_ok = ({1'b0, cnt_q} + {2'b00, out_q}) < 3'd2;
        // A response retiring this cycle frees the single outstanding slot.
        req       = reset && credit_ok && (!out_q || rsp);
        accept    = req && IMEM_READY;
        push      = rsp && !drop_q && !redirect;
        // The edge where a branch leaves decode advances a bubble, keeping the
        // fall-through words queued until the branch resolves.
        pop       = !redirect && !MEM_STALL && (state_q == ST_RUN) && (cnt_q != 2'd0)
                    && !(de_v_q && DE_BR_STALL);
        wr_idx    = hd_q ^ cnt_q[0];
    end

    assign IMEM_REQ  = req;
    assign IMEM_ADDR = fetch_pc;
    assign DE_NPC    = de_npc_q;
    assign DE_IR     = de_ir_q;
    assign DE_V      = de_v_q;
    assign DBG_STATE = state_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = redirect ? redir_pc : pc_q;
        req_pc_d = req_pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        hd_d     = pop ? ~hd_q : hd_q;
        de_npc_d = de_npc_q;
        de_ir_d  = de_ir_q;
        de_v_d   = de_v_q;

        if (rsp) begin
            out_d  = 1'b0;
            drop_d = 1'b0;
        end
        if (accept) begin
            out_d    = 1'b1;
            req_pc_d = fetch_pc;
            pc_d     = fetch_pc + 64'd4;
        end

        if (redirect) begin
            cnt_d   = 2'd0;
            drop_d  = out_q && !IMEM_RVALID;
            de_v_d  = 1'b0;
            de_ir_d = NOP_IR;
            state_d = ST_RUN;
        end else begin
            if (!MEM_STALL) begin
                de_v_d = pop;
                if (pop) begin
                    de_npc_d = q_npc_q[hd_q];
                    de_ir_d  = q_ir_q[hd_q];
                end
            end
            case (state_q)
                ST_RUN:     if (de_v_q && DE_BR_STALL && !MEM_STALL) state_d = ST_BR_WAIT;
                ST_BR_WAIT: if (BR_RESOLVE) state_d = ST_RUN;
                default:    state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            out_q      <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= 2'd0;
            hd_q       <= 1'b0;
            q_npc_q[0] <= 64'h0;
            q_npc_q[1] <= 64'h0;
            q_ir_q[0]  <= NOP_IR;
            q_ir_q[1]  <= NOP_IR;
            de_npc_q   <= 64'h0;
            de_ir_q    <= NOP_IR;
            de_v_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            hd_q     <= hd_d;
            if (push) begin
                q_npc_q[wr_idx] <= req_pc_q + 64'd4;
                q_ir_q[wr_idx]  <= IMEM_RDATA;
            end
            de_npc_q <= de_npc_d;
            de_ir_q  <= de_ir_d;
            de_v_q   <= de_v_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for zero-wait streaming plus
// hand-written stall, branch, redirect-drop, trap-priority and async-reset sequences.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        MEM_STALL = 1'b0, DE_BR_STALL = 1'b0, BR_RESOLVE = 1'b0, BR_TAKEN = 1'b0;
    logic [63:0] BR_TARGET = 64'h0, DE_MTVEC = 64'h0;
    logic        TRAP = 1'b0;
    logic        IMEM_REQ, IMEM_READY = 1'b1, IMEM_RVALID = 1'b0;
    logic [63:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic        DE_V, DBG_STATE;

    fetch_stage #(.RESET_PC(64'h1000), .NOP_IR(32'h00000013)) dut (
        .CLK(CLK), .reset(reset), .MEM_STALL(MEM_STALL), .DE_BR_STALL(DE_BR_STALL),
        .BR_RESOLVE(BR_RESOLVE), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .TRAP(TRAP), .DE_MTVEC(DE_MTVEC), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_READY(IMEM_READY), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .DE_NPC(DE_NPC), .DE_IR(DE_IR), .DE_V(DE_V), .DBG_STATE(DBG_STATE)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // memory model + consumed-instruction monitor
    int          mem_lat = 1;
    logic        mem_ready = 1'b1;
    logic        pend = 1'b0;
    logic [63:0] paddr = 64'h0;
    int          cnt = 0;
    logic        acc_s, rv_s;
    logic [63:0] addr_s;
    logic        mon_en = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [31:0] got_ir_q[$];

    function automatic logic [31:0] wdata(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always begin
        @(negedge CLK);
        if (pend) begin
            if (cnt <= 1) begin
                IMEM_RVALID = 1'b1;
                IMEM_RDATA  = wdata(paddr);
            end else begin
                IMEM_RVALID = 1'b0;
                cnt = cnt - 1;
            end
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = 32'h0;
        end
        IMEM_READY = mem_ready;
        #3;
        acc_s  = reset && IMEM_REQ && IMEM_READY;
        rv_s   = IMEM_RVALID;
        addr_s = IMEM_ADDR;
        if (mon_en && reset && DE_V && !MEM_STALL) begin
            got_q.push_back(DE_NPC);
            got_ir_q.push_back(DE_IR);
        end
        @(posedge CLK);
        if (!reset) pend = 1'b0;
        else begin
            if (rv_s) pend = 1'b0;
            if (acc_s) begin
                pend  = 1'b1;
                paddr = addr_s;
                cnt   = mem_lat;
            end
        end
    end

    // scoreboard helpers
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_stream(input string nm);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k >= got_q.size()) begin
                total++;
                bad++;
                $display("FAIL %s[%0d]: got nothing want npc %h", nm, k, exp_q[k]);
            end else begin
                chk({nm, "_npc"}, got_q[k], exp_q[k]);
                chk({nm, "_ir"}, {32'h0, got_ir_q[k]}, {32'h0, wdata(exp_q[k] - 64'd4)});
            end
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_ir_q.delete();
        exp_q.delete();
    endtask

    // driver tasks
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        MEM_STALL = 1'b0; DE_BR_STALL = 1'b0; BR_RESOLVE = 1'b0; BR_TAKEN = 1'b0;
        TRAP = 1'b0; BR_TARGET = 64'h0; DE_MTVEC = 64'h0;
        mem_lat = 1; mem_ready = 1'b1; mon_en = 1'b0;
        repeat (2) @(negedge CLK);
        #2;
        chk("rst_req", {63'h0, IMEM_REQ}, 64'h0);
        chk("rst_npc", DE_NPC, 64'h0);
        chk("rst_ir", {32'h0, DE_IR}, 64'h13);
        chk("rst_v", {63'h0, DE_V}, 64'h0);
        @(negedge CLK);
        reset = 1'b1;
    endtask

    // trap to 0x2000 at c0, branch sits in DE at c3 and leaves with DE_BR_STALL
    task automatic branch_setup();
        do_reset();
        TRAP = 1'b1; DE_MTVEC = 64'h2000;
        #2 chk("br_trap_addr", IMEM_ADDR, 64'h2000);
        step(); TRAP = 1'b0;
        clear_mon(); mon_en = 1'b1;
        step(); step();
        DE_BR_STALL = 1'b1;
        #2;
        chk("br_in_de_v", {63'h0, DE_V}, 64'h1);
        chk("br_in_de_npc", DE_NPC, 64'h2004);
        step(); DE_BR_STALL = 1'b0;
        #2;
        chk("br_wait_v", {63'h0, DE_V}, 64'h0);
        chk("br_wait_state", {63'h0, DBG_STATE}, 64'h1);
    endtask

    typedef struct {
        logic        req;
        logic [63:0] addr;
        logic        v;
        logic [63:0] npc;
        logic [31:0] ir;
    } vec_t;
    vec_t tv[8];

    initial begin
        tv[0] = '{1'b1, 64'h1000, 1'b0, 64'h0,    32'h00000013};
        tv[1] = '{1'b1, 64'h1004, 1'b0, 64'h0,    32'h00000013};
        tv[2] = '{1'b0, 64'h1008, 1'b0, 64'h0,    32'h00000013};
        tv[3] = '{1'b1, 64'h1008, 1'b1, 64'h1004, 32'hC0DE1000};
        tv[4] = '{1'b1, 64'h100C, 1'b1, 64'h1008, 32'hC0DE1004};
        tv[5] = '{1'b0, 64'h1010, 1'b0, 64'h1008, 32'hC0DE1004};
        tv[6] = '{1'b1, 64'h1010, 1'b1, 64'h100C, 32'hC0DE1008};
        tv[7] = '{1'b1, 64'h1014, 1'b1, 64'h1010, 32'hC0DE100C};

        // zero-wait streaming, cycle by cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            #2;
            chk($sformatf("t1_req_c%0d", i), {63'h0, IMEM_REQ}, {63'h0, tv[i].req});
            chk($sformatf("t1_addr_c%0d", i), IMEM_ADDR, tv[i].addr);
            chk($sformatf("t1_v_c%0d", i), {63'h0, DE_V}, {63'h0, tv[i].v});
            chk($sformatf("t1_npc_c%0d", i), DE_NPC, tv[i].npc);
            chk($sformatf("t1_ir_c%0d", i), {32'h0, DE_IR}, {32'h0, tv[i].ir});
        end

        // MEM_STALL for 4 cycles mid-stream
        do_reset();
        clear_mon(); mon_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) step();
            MEM_STALL = (i >= 3 && i <= 6);
            #2;
            if (i >= 4 && i <= 6) begin
                chk($sformatf("t2_hold_npc_c%0d", i), DE_NPC, 64'h1004);
                chk($sformatf("t2_hold_v_c%0d", i), {63'h0, DE_V}, 64'h1);
                chk($sformatf("t2_hold_req_c%0d", i), {63'h0, IMEM_REQ}, 64'h0);
            end
        end
        for (int k = 0; k < 10; k++) exp_q.push_back(64'h1004 + 64'(4 * k));
        chk_stream("t2_stream");

        // taken branch
        branch_setup();
        step();
        BR_RESOLVE = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 64'h3000;
        #2;
        chk("t3_resolve_v", {63'h0, DE_V}, 64'h0);
        chk("t3_retarget_addr", IMEM_ADDR, 64'h3000);
        step();
        BR_RESOLVE = 1'b0; BR_TAKEN = 1'b0;
        #2;
        chk("t3_req", {63'h0, IMEM_REQ}, 64'h1);
        chk("t3_addr", IMEM_ADDR, 64'h3000);
        chk("t3_state", {63'h0, DBG_STATE}, 64'h0);
        repeat (10) step();
        exp_q.push_back(64'h2004); exp_q.push_back(64'h3004); exp_q.push_back(64'h3008);
        chk_stream("t3_stream");

        // not-taken branch keeps the queued fall-through
        branch_setup();
        step();
        BR_RESOLVE = 1'b1; BR_TAKEN = 1'b0; BR_TARGET = 64'h3000;
        step();
        BR_RESOLVE = 1'b0;
        #2 chk("t4_state", {63'h0, DBG_STATE}, 64'h0);
        repeat (10) step();
        exp_q.push_back(64'h2004); exp_q.push_back(64'h2008);
        exp_q.push_back(64'h200C); exp_q.push_back(64'h2010);
        chk_stream("t4_stream");

        // redirect with a slow response outstanding: late word must be dropped
        do_reset();
        mem_lat = 3;
        step();
        TRAP = 1'b1; DE_MTVEC = 64'h5000;
        #2 chk("t5_req_blocked", {63'h0, IMEM_REQ}, 64'h0);
        step();
        TRAP = 1'b0;
        clear_mon(); mon_en = 1'b1;
        step();
        #2;
        chk("t5_req_on_rsp", {63'h0, IMEM_REQ}, 64'h1);
        chk("t5_addr_on_rsp", IMEM_ADDR, 64'h5000);
        repeat (12) step();
        exp_q.push_back(64'h5004); exp_q.push_back(64'h5008);
        chk_stream("t5_stream");

        // TRAP beats taken branch; response in the redirect cycle is discarded
        branch_setup();
        TRAP = 1'b1; DE_MTVEC = 64'h8000;
        BR_RESOLVE = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 64'h3000;
        #2 chk("t6_addr", IMEM_ADDR, 64'h8000);
        step();
        TRAP = 1'b0; BR_RESOLVE = 1'b0; BR_TAKEN = 1'b0;
        clear_mon();
        #2;
        chk("t6_req", {63'h0, IMEM_REQ}, 64'h1);
        chk("t6_addr_next", IMEM_ADDR, 64'h8000);
        repeat (10) step();
        exp_q.push_back(64'h8004); exp_q.push_back(64'h8008);
        chk_stream("t6_stream");

        // asynchronous reset mid-stream
        do_reset();
        repeat (7) step();
        #2;
        chk("t7_pre_v", {63'h0, DE_V}, 64'h1);
        reset = 1'b0;
        #1;
        chk("t7_async_v", {63'h0, DE_V}, 64'h0);
        chk("t7_async_ir", {32'h0, DE_IR}, 64'h13);
        chk("t7_async_req", {63'h0, IMEM_REQ}, 64'h0);
        chk("t7_async_npc", DE_NPC, 64'h0);
        step(); step();
        reset = 1'b1;
        #2;
        chk("t7_restart_req", {63'h0, IMEM_REQ}, 64'h1);
        chk("t7_restart_addr", IMEM_ADDR, 64'h1000);
        repeat (3) step();
        #2;
        chk("t7_restart_v", {63'h0, DE_V}, 64'h1);
        chk("t7_restart_npc", DE_NPC, 64'h1004);
        chk("t7_restart_ir", {32'h0, DE_IR}, {32'h0, wdata(64'h1000)});

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
